// File: rtl/buffer_pkg.sv
// Shared constants and address-width helper for the camera-to-HDMI line buffering path.
package buffer_pkg;

   localparam int DEFAULT_DATA_W    = 16;
   localparam int DEFAULT_LINE_LEN  = 1280;
   localparam int DEFAULT_NUM_LINES = 4;

   // Address width of a RAM holding num_lines lines of line_len pixels.
   function automatic int ram_addr_w(input int line_len, input int num_lines);
      return (line_len * num_lines > 1) ? $clog2(line_len * num_lines) : 1;
   endfunction

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port, read-before-write.
module sdp_ram #(
   parameter  int DATA_W = 16,
   parameter  int DEPTH  = 1024,
   localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic              i_clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] rd_data_reg;

   always_ff @(posedge i_clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      rd_data_reg <= mem[rd_addr];
   end

   assign rd_data = rd_data_reg;

endmodule

// File: rtl/rgb_line_ring_buffer.sv
// Ring of NUM_LINES pixel lines: camera writes a stream, HDMI reads and releases the
// oldest complete line. Tracks occupancy, full, overflow and start-of-frame realignment.
module rgb_line_ring_buffer
   import buffer_pkg::*;
#(
   parameter  int DATA_W    = DEFAULT_DATA_W,
   parameter  int LINE_LEN  = DEFAULT_LINE_LEN,
   parameter  int NUM_LINES = DEFAULT_NUM_LINES,
   localparam int COL_W     = $clog2(LINE_LEN),
   localparam int LVL_W     = $clog2(NUM_LINES + 1)
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_wr_en,
   input  logic [DATA_W-1:0] i_wr_data,
   input  logic              i_sof,
   input  logic [COL_W-1:0]  i_rd_addr,
   input  logic              i_line_done,
   output logic [DATA_W-1:0] o_rd_data,
   output logic              o_line_valid,
   output logic              o_line_pulse,
   output logic [LVL_W-1:0]  o_level,
   output logic              o_full,
   output logic              o_overflow
);

   localparam int                LINE_W     = $clog2(NUM_LINES);
   localparam int                ADDR_W     = ram_addr_w(LINE_LEN, NUM_LINES);
   localparam logic [COL_W-1:0]  LAST_COL   = COL_W'(LINE_LEN - 1);
   localparam logic [LINE_W-1:0] LAST_LINE  = LINE_W'(NUM_LINES - 1);
   localparam logic [LVL_W-1:0]  LVL_FULL   = LVL_W'(NUM_LINES);
   localparam logic [COL_W:0]    LINE_LEN_C = (COL_W + 1)'(LINE_LEN);
   localparam logic [ADDR_W-1:0] LINE_LEN_A = ADDR_W'(LINE_LEN);

   logic [COL_W-1:0]  wr_col_reg,  wr_col_next;
   logic [LINE_W-1:0] wr_line_reg, wr_line_next;
   logic [LINE_W-1:0] rd_line_reg, rd_line_next;
   logic [LVL_W-1:0]  level_reg,   level_next;
   logic              full_reg, valid_reg, pulse_reg, overflow_reg, rd_zero_reg;

   logic              accept, complete, line_release, rd_in_range;
   logic [COL_W-1:0]  wr_col_eff, rd_col;
   logic [ADDR_W-1:0] wr_addr, rd_addr;
   logic [DATA_W-1:0] ram_rd_data;

   always_comb begin
      accept       = i_wr_en & ~full_reg;
      // A start-of-frame pixel always lands in column 0, so it can never finish a line.
      complete     = accept & ~i_sof & (wr_col_reg == LAST_COL);
      line_release = i_line_done & (level_reg != '0);

      wr_col_next  = wr_col_reg;
      wr_line_next = wr_line_reg;
      rd_line_next = rd_line_reg;
      level_next   = level_reg;

      if (i_sof) begin
         wr_col_next = accept ? COL_W'(1) : '0;
      end else if (complete) begin
         wr_col_next  = '0;
         wr_line_next = (wr_line_reg == LAST_LINE) ? '0 : wr_line_reg + 1'b1;
      end else if (accept) begin
         wr_col_next = wr_col_reg + 1'b1;
      end

      if (line_release) begin
         rd_line_next = (rd_line_reg == LAST_LINE) ? '0 : rd_line_reg + 1'b1;
      end

      case ({complete, line_release})
         2'b10:   level_next = level_reg + 1'b1;
         2'b01:   level_next = level_reg - 1'b1;
         default: level_next = level_reg;
      endcase

      wr_col_eff  = i_sof ? '0 : wr_col_reg;
      wr_addr     = ADDR_W'(wr_line_reg) * LINE_LEN_A + ADDR_W'(wr_col_eff);
      rd_in_range = {1'b0, i_rd_addr} < LINE_LEN_C;
      // Out-of-range columns still read a legal RAM word; the result is masked to zero.
      rd_col      = rd_in_range ? i_rd_addr : '0;
      rd_addr     = ADDR_W'(rd_line_reg) * LINE_LEN_A + ADDR_W'(rd_col);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_col_reg   <= '0;
         wr_line_reg  <= '0;
         rd_line_reg  <= '0;
         level_reg    <= '0;
         full_reg     <= 1'b0;
         valid_reg    <= 1'b0;
         pulse_reg    <= 1'b0;
         overflow_reg <= 1'b0;
         rd_zero_reg  <= 1'b1;
      end else begin
         wr_col_reg   <= wr_col_next;
         wr_line_reg  <= wr_line_next;
         rd_line_reg  <= rd_line_next;
         level_reg    <= level_next;
         full_reg     <= (level_next == LVL_FULL);
         valid_reg    <= (level_next != '0);
         pulse_reg    <= complete;
         overflow_reg <= overflow_reg | (i_wr_en & full_reg);
         rd_zero_reg  <= ~rd_in_range;
      end
   end

   sdp_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (LINE_LEN * NUM_LINES)
   ) u_ram (
      .i_clk   (i_clk),
      .wr_en   (accept & ~i_rst),
      .wr_addr (wr_addr),
      .wr_data (i_wr_data),
      .rd_addr (rd_addr),
      .rd_data (ram_rd_data)
   );

   assign o_rd_data    = rd_zero_reg ? '0 : ram_rd_data;
   assign o_line_valid = valid_reg;
   assign o_line_pulse = pulse_reg;
   assign o_level      = level_reg;
   assign o_full       = full_reg;
   assign o_overflow   = overflow_reg;

endmodule

// File: tb/tb_rgb_line_ring_buffer.sv
// Scoreboard bench: a queue-of-pixels model predicts each cycle's outputs; a monitor checks them.
module tb_rgb_line_ring_buffer;

   localparam int DATA_W    = 16;
   localparam int LINE_LEN  = 10;
   localparam int NUM_LINES = 3;
   localparam int COL_W     = $clog2(LINE_LEN);
   localparam int LVL_W     = $clog2(NUM_LINES + 1);

   typedef logic [DATA_W-1:0] pix_t;

   typedef struct {
      bit   chk_rd;
      pix_t rd;
      int   level;
      bit   full;
      bit   valid;
      bit   pulse;
      bit   ovf;
   } exp_t;

   logic              clk;
   logic              i_rst, i_wr_en, i_sof, i_line_done;
   logic [DATA_W-1:0] i_wr_data;
   logic [COL_W-1:0]  i_rd_addr;
   logic [DATA_W-1:0] o_rd_data;
   logic              o_line_valid, o_line_pulse, o_full, o_overflow;
   logic [LVL_W-1:0]  o_level;

   exp_t exp_q[$];
   pix_t partial_q[$];
   pix_t done_pix[$];     // completed lines, oldest first, LINE_LEN pixels each
   bit   m_ovf;
   int   n_cmp = 0;
   int   n_bad = 0;

   rgb_line_ring_buffer #(
      .DATA_W    (DATA_W),
      .LINE_LEN  (LINE_LEN),
      .NUM_LINES (NUM_LINES)
   ) dut (
      .i_clk        (clk),
      .i_rst        (i_rst),
      .i_wr_en      (i_wr_en),
      .i_wr_data    (i_wr_data),
      .i_sof        (i_sof),
      .i_rd_addr    (i_rd_addr),
      .i_line_done  (i_line_done),
      .o_rd_data    (o_rd_data),
      .o_line_valid (o_line_valid),
      .o_line_pulse (o_line_pulse),
      .o_level      (o_level),
      .o_full       (o_full),
      .o_overflow   (o_overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
      end
   endfunction

   // Drive one cycle of stimulus and queue the outputs expected after the next edge.
   task automatic step(input bit rst, input bit wr, input bit sof, input bit done,
                       input pix_t data, input int addr);
      exp_t e;
      int   lvl;
      @(negedge clk);
      i_rst       = rst;
      i_wr_en     = wr;
      i_sof       = sof;
      i_line_done = done;
      i_wr_data   = data;
      i_rd_addr   = COL_W'(addr);
      lvl         = done_pix.size() / LINE_LEN;
      e.chk_rd    = 1'b0;
      e.rd        = '0;
      e.pulse     = 1'b0;
      if (rst) begin
         partial_q.delete();
         done_pix.delete();
         m_ovf    = 1'b0;
         e.chk_rd = 1'b1;
      end else begin
         if (addr >= LINE_LEN) begin
            e.chk_rd = 1'b1;
         end else if (lvl > 0) begin
            e.chk_rd = 1'b1;
            e.rd     = done_pix[addr];
         end
         if (wr && lvl == NUM_LINES) m_ovf = 1'b1;
         if (sof) partial_q.delete();
         if (wr && lvl < NUM_LINES) begin
            partial_q.push_back(data);
            if (partial_q.size() == LINE_LEN) begin
               foreach (partial_q[k]) done_pix.push_back(partial_q[k]);
               partial_q.delete();
               e.pulse = 1'b1;
            end
         end
         if (done && lvl > 0) begin
            repeat (LINE_LEN) void'(done_pix.pop_front());
         end
      end
      e.level = done_pix.size() / LINE_LEN;
      e.full  = (e.level == NUM_LINES);
      e.valid = (e.level != 0);
      e.ovf   = m_ovf;
      exp_q.push_back(e);
   endtask

   always @(posedge clk) begin : monitor
      exp_t e;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("level",    32'(o_level),      32'(e.level));
         chk("full",     32'(o_full),       32'(e.full));
         chk("valid",    32'(o_line_valid), 32'(e.valid));
         chk("pulse",    32'(o_line_pulse), 32'(e.pulse));
         chk("overflow", 32'(o_overflow),   32'(e.ovf));
         if (e.chk_rd) chk("rd_data", 32'(o_rd_data), 32'(e.rd));
         if (o_line_pulse) $display("line complete: level=%0d overflow=%0d", o_level, o_overflow);
      end
   end

   initial begin
      i_rst = 1'b1; i_wr_en = 1'b0; i_sof = 1'b0; i_line_done = 1'b0;
      i_wr_data = '0; i_rd_addr = '0;
      repeat (2) step(1, 0, 0, 0, '0, 0);

      // First line 0..9, then read column 5
      for (int i = 0; i < LINE_LEN; i++) step(0, 1, 0, 0, pix_t'(i), 0);
      step(0, 0, 0, 0, '0, 5);
      step(0, 0, 0, 0, '0, 9);

      // Fill to full, drop one pixel, prove the oldest line survived, then release
      for (int i = 0; i < 2 * LINE_LEN; i++) step(0, 1, 0, 0, pix_t'(16'h100 + i), 0);
      step(0, 1, 0, 0, 16'hDEAD, 0);
      for (int c = 0; c < LINE_LEN; c++) step(0, 0, 0, 0, '0, c);
      step(0, 0, 0, 1, '0, 0);
      for (int c = 0; c < LINE_LEN; c++) step(0, 0, 0, 0, '0, c);

      // Completion and release in the same cycle at level 2
      for (int i = 0; i < LINE_LEN - 1; i++) step(0, 1, 0, 0, pix_t'(16'h200 + i), 0);
      step(0, 1, 0, 1, 16'h2FF, 3);
      for (int c = 0; c < LINE_LEN; c++) step(0, 0, 0, 0, '0, c);

      // Drain, plus a release at level 0 and an out-of-range read
      repeat (3) step(0, 0, 0, 1, '0, 0);
      step(0, 0, 0, 1, '0, LINE_LEN + 2);
      step(0, 0, 0, 0, '0, LINE_LEN + 5);

      // Partial line discarded by start of frame, then one clean line
      for (int i = 0; i < 7; i++) step(0, 1, 0, 0, pix_t'(16'h300 + i), 0);
      step(0, 0, 1, 0, '0, 0);
      for (int i = 0; i < LINE_LEN; i++) step(0, 1, 0, 0, 16'hA5A5, 0);
      for (int c = 0; c < LINE_LEN; c++) step(0, 0, 0, 0, '0, c);
      step(0, 0, 0, 1, '0, 0);

      // Reset mid-line
      for (int i = 0; i < 4; i++) step(0, 1, 0, 0, pix_t'(i), 0);
      step(1, 1, 0, 0, '0, 0);
      step(0, 0, 0, 0, '0, 0);

      // Randomised traffic: sparse releases first (fills/overflows), then frequent ones
      for (int i = 0; i < 4000; i++) begin
         bit rst, wr, sof, done;
         rst  = ($urandom_range(0, 599) == 0);
         wr   = ($urandom_range(0, 99) < 75);
         sof  = ($urandom_range(0, 99) < 2);
         done = ($urandom_range(0, 99) < ((i < 2000) ? 5 : 25));
         step(rst, wr, sof, done, pix_t'($urandom), int'($urandom_range(0, (1 << COL_W) - 1)));
      end

      step(0, 0, 0, 0, '0, 0);
      repeat (3) @(posedge clk);
      #2;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
